// File: rtl/encoder83_arb.sv
// encoder83_arb: sequential N-to-W priority encoder with request capture.
// Rising edges on Ip are latched into a sticky pending set; the winning
// index is presented on Op with a valid/ack handshake so a consumer can
// drain requests one per cycle. All outputs are registered.
module encoder83_arb #(
   parameter int unsigned N          = 8,
   parameter int unsigned W          = 3,
   parameter int unsigned HIGH_FIRST = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         EN,
   input  logic [N-1:0] Ip,
   input  logic         ack,
   output logic [W-1:0] Op,
   output logic         valid,
   output logic [W:0]   pending_cnt,
   output logic         lost
);

   logic [N-1:0] ip_prev;
   logic [N-1:0] pending;
   logic [N-1:0] rise;
   logic [N-1:0] load_mask;
   logic [N-1:0] busy_mask;
   logic [N-1:0] pend_nxt;
   logic [N-1:0] one_hot0;
   logic [W-1:0] pick;
   logic         found;
   logic         xfer;
   logic         lost_nxt;
   logic [W:0]   cnt_nxt;

   // Priority pick over the registered pending set; later loop hits override earlier ones
   always_comb begin
      pick  = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (HIGH_FIRST != 0) begin
            if (pending[i]) begin
               pick  = W'(i);
               found = 1'b1;
            end
         end else begin
            if (pending[N-1-i]) begin
               pick  = W'(N-1-i);
               found = 1'b1;
            end
         end
      end
   end

   // Edge detect, next pending set, overflow detect and next-state popcount
   always_comb begin
      one_hot0  = {{(N-1){1'b0}}, 1'b1};
      rise      = Ip & ~ip_prev;
      xfer      = ~valid | ack;
      load_mask = (xfer && found) ? (one_hot0 << pick) : '0;
      busy_mask = (valid && !ack) ? (one_hot0 << Op) : '0;
      // clear the loaded bit first so a same-edge rise on it re-arms instead of being lost
      pend_nxt  = (pending & ~load_mask) | (EN ? rise : '0);
      lost_nxt  = EN && (|(rise & ((pending & ~load_mask) | busy_mask)));
      cnt_nxt   = '0;
      for (int unsigned i = 0; i < N; i++) begin
         cnt_nxt = cnt_nxt + (W+1)'(pend_nxt[i]);
      end
   end

   // State register: synchronous reset overrides capture and handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         ip_prev     <= '0;
         pending     <= '0;
         Op          <= '0;
         valid       <= 1'b0;
         pending_cnt <= '0;
         lost        <= 1'b0;
      end else begin
         ip_prev     <= Ip;
         pending     <= pend_nxt;
         pending_cnt <= cnt_nxt;
         lost        <= lost_nxt;
         if (xfer) begin
            if (found) begin
               Op    <= pick;
               valid <= 1'b1;
            end else begin
               valid <= 1'b0;
            end
         end
      end
   end

endmodule
